// File: rtl/tm_input_sequencer_if.sv
// Pin-side word stream and core-side load/step handshake of the Turing machine input sequencer.
// master = pins/core environment, slave = the sequencer itself.
interface tm_input_sequencer_if #(
  parameter int DW = 4
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] input_data;
  logic          Next;
  logic          Done;
  logic          Compute_done;

  modport master (
    output in_data, in_valid, in_last, Compute_done,
    input  in_ready, input_data, Next, Done
  );

  modport slave (
    input  in_data, in_valid, in_last, Compute_done,
    output in_ready, input_data, Next, Done
  );
endinterface

// File: rtl/tm_input_sequencer.sv
// Buffers a pin word stream in a FIFO and replays it to the core with Next/Done strobes, then steps it.
// Word pushed into an empty FIFO shows Next two cycles later; in_ready drops when full or after the last word.
module tm_input_sequencer #(
  parameter int DW       = 4,
  parameter int DEPTH    = 8,
  parameter int HOLD     = 2,
  parameter int GAP      = 2,
  parameter int STEP_DIV = 16
) (
  input  logic                 clock,
  input  logic                 Reset,
  tm_input_sequencer_if.slave  bus,
  input  logic                 run_en,
  input  logic                 step_req,
  output logic [15:0]          step_count,
  output logic                 halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW = $clog2(HG + 1);
  localparam int TW = $clog2(STEP_DIV);

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [TW-1:0] TMR_END  = TW'(STEP_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_HI  = 3'd1,
    LOAD_LO  = 3'd2,
    DONE_P   = 3'd3,
    RUN_WAIT = 3'd4,
    STEP_HI  = 3'd5,
    STEP_LO  = 3'd6,
    HALTED   = 3'd7
  } state_t;

  state_t state_q, state_d;

  // FIFO entries carry the word with its last flag in the MSB.
  logic [DW:0]   mem_q [DEPTH];
  logic [DW:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          last_seen_q, last_seen_d;

  logic [CW-1:0] ph_cnt_q, ph_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          step_req_q, step_req_d;
  logic          last_word_q, last_word_d;
  logic [DW-1:0] input_data_q, input_data_d;
  logic          next_q, next_d;
  logic          done_q, done_d;
  logic [15:0]   step_count_q, step_count_d;
  logic          halted_q, halted_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          in_ready_int;
  logic          push;
  logic          pop;
  logic [DW:0]   head;
  logic          step_edge;
  logic          step_take;
  logic          edge_window;

  // FIFO
  always_comb begin
    fifo_full    = (fill_q == FULL_CNT);
    fifo_empty   = (fill_q == '0);
    in_ready_int = ~fifo_full & ~last_seen_q;
    push         = bus.in_valid & in_ready_int;
    pop          = (state_q == IDLE) & ~fifo_empty;
    head         = mem_q[rd_ptr_q];

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    last_seen_d = last_seen_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_last, bus.in_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      last_seen_d     = last_seen_q | bus.in_last;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, phase counter, step timer and pending manual step
  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    timer_d    = '0;
    pend_d     = pend_q;
    step_req_d = step_req;
    step_edge  = step_req & ~step_req_q;
    step_take  = 1'b0;

    edge_window = (state_q == DONE_P) || (state_q == RUN_WAIT) ||
                  (state_q == STEP_HI) || (state_q == STEP_LO);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = LOAD_HI;
          ph_cnt_d = '0;
        end
      end
      LOAD_HI: begin
        if (ph_cnt_q == HOLD_END) begin
          state_d  = LOAD_LO;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      LOAD_LO: begin
        if (ph_cnt_q == GAP_END) begin
          state_d  = last_word_q ? DONE_P : IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      DONE_P: begin
        state_d = RUN_WAIT;
      end
      RUN_WAIT: begin
        if (bus.Compute_done) begin
          state_d = HALTED;
        end else if (pend_q || step_edge || (run_en && (timer_q == TMR_END))) begin
          state_d   = STEP_HI;
          ph_cnt_d  = '0;
          step_take = 1'b1;
        end else begin
          timer_d = run_en ? (timer_q + 1'b1) : timer_q;
        end
      end
      STEP_HI: begin
        if (ph_cnt_q == HOLD_END) begin
          state_d  = STEP_LO;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      STEP_LO: begin
        if (ph_cnt_q == GAP_END) begin
          state_d  = RUN_WAIT;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An edge seen in the same cycle a step is taken is consumed by that step.
    if (step_take) begin
      pend_d = 1'b0;
    end else if (edge_window && step_edge) begin
      pend_d = 1'b1;
    end
  end

  // FSM outputs; strobes are registered from the current state
  always_comb begin
    next_d       = (state_q == LOAD_HI) || (state_q == STEP_HI);
    done_d       = (state_q == DONE_P);
    halted_d     = (state_q == HALTED);
    input_data_d = pop ? head[DW-1:0] : input_data_q;
    last_word_d  = pop ? head[DW] : last_word_q;
    step_count_d = step_count_q;
    if (step_take && (step_count_q != 16'hFFFF)) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      last_seen_q  <= 1'b0;
      ph_cnt_q     <= '0;
      timer_q      <= '0;
      pend_q       <= 1'b0;
      step_req_q   <= 1'b0;
      last_word_q  <= 1'b0;
      input_data_q <= '0;
      next_q       <= 1'b0;
      done_q       <= 1'b0;
      step_count_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      last_seen_q  <= last_seen_d;
      ph_cnt_q     <= ph_cnt_d;
      timer_q      <= timer_d;
      pend_q       <= pend_d;
      step_req_q   <= step_req_d;
      last_word_q  <= last_word_d;
      input_data_q <= input_data_d;
      next_q       <= next_d;
      done_q       <= done_d;
      step_count_q <= step_count_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.input_data = input_data_q;
  assign bus.Next       = next_q;
  assign bus.Done       = done_q;
  assign step_count     = step_count_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Scoreboard bench for tm_input_sequencer: replayed words, pulse shapes, stepping, halt and reset.
module tb_tm_input_sequencer;
  localparam int DW   = 4;
  localparam int HOLD = 2;
  localparam int GAP  = 2;

  logic        clock    = 1'b0;
  logic        Reset    = 1'b0;
  logic        run_en   = 1'b0;
  logic        step_req = 1'b0;
  logic [15:0] step_count;
  logic        halted;

  tm_input_sequencer_if #(.DW(DW)) bus ();

  tm_input_sequencer #(
    .DW(DW), .DEPTH(8), .HOLD(HOLD), .GAP(GAP), .STEP_DIV(16)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .bus(bus),
    .run_en(run_en),
    .step_req(step_req),
    .step_count(step_count),
    .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] exp_q[$];
  int            rise_cyc[$];
  logic          nx_prev = 1'b0;
  logic          dn_prev = 1'b0;
  int            hi_len = 0, lo_len = 0;
  int            loads = 0, steps = 0, dones = 0, done_cyc = 0;
  logic [DW-1:0] cur_dat = '0;
  int            st, first_stall, n;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Observes Next/Done once per cycle on the falling edge.
  task automatic mon_step();
    cyc++;
    if (Reset) begin
      nx_prev = 1'b0; dn_prev = 1'b0;
      hi_len = 0; lo_len = 0; loads = 0; steps = 0; dones = 0;
      exp_q.delete();
      rise_cyc.delete();
    end else begin
      if (bus.Next) begin
        if (!nx_prev) begin
          if (loads + steps > 0) chk("next_lo_min", int'(lo_len >= GAP), 1);
          hi_len = 1;
          if (dones == 0) begin
            if (exp_q.size() == 0) chk("load_unexpected", 1, 0);
            else chk("load_dat", int'(bus.input_data), int'(exp_q.pop_front()));
            cur_dat = bus.input_data;
            loads++;
          end else begin
            steps++;
            rise_cyc.push_back(cyc);
          end
        end else begin
          hi_len++;
          if (dones == 0) chk("dat_stable", int'(bus.input_data), int'(cur_dat));
        end
      end else begin
        if (nx_prev) begin
          chk("next_hi_len", hi_len, HOLD);
          lo_len = 1;
        end else begin
          lo_len++;
        end
      end
      if (bus.Done) begin
        if (dn_prev) chk("done_width", 2, 1);
        else chk("done_after_gap", lo_len, GAP + 1);
        dones++;
        done_cyc = cyc;
      end
      nx_prev = bus.Next;
      dn_prev = bus.Done;
    end
  endtask

  // Entered at a falling edge; returns at the falling edge after the word was taken.
  task automatic send(input logic [DW-1:0] d, input logic l, output int stalls);
    stalls       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && stalls < 100) begin
      stalls++;
      @(negedge clock);
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    else exp_q.push_back(d);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    Reset = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (dones == 0 && k < max) begin
      @(negedge clock);
      k++;
    end
    if (dones == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_next(input logic lvl, input int max);
    int k = 0;
    while (bus.Next != lvl && k < max) begin
      @(negedge clock);
      k++;
    end
    if (bus.Next != lvl) chk("next_timeout", 0, 1);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.Compute_done = 1'b0;
    fork
      forever begin
        @(negedge clock);
        mon_step();
      end
    join_none

    #1 Reset = 1'b1;
    #3;
    chk("rst_next", int'(bus.Next), 0);
    chk("rst_done", int'(bus.Done), 0);
    chk("rst_input_data", int'(bus.input_data), 0);
    chk("rst_step_count", int'(step_count), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);

    // Three words, last on the third; no stepping afterwards with run_en low.
    do_reset();
    send(4'd3, 1'b0, st);
    send(4'd5, 1'b0, st);
    send(4'd9, 1'b1, st);
    chk("ready_after_last", int'(bus.in_ready), 0);
    wait_done(100);
    repeat (40) @(negedge clock);
    chk("t1_loads", loads, 3);
    chk("t1_dones", dones, 1);
    chk("t1_steps", steps, 0);
    chk("t1_step_count", int'(step_count), 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Burst of 12 words: FIFO fills after 10 accepted words (two pops in between).
    do_reset();
    first_stall = -1;
    for (int i = 0; i < 12; i++) begin
      send(DW'(i + 1), (i == 11), st);
      if (st > 0 && first_stall < 0) first_stall = i;
    end
    chk("fill_first_stall", first_stall, 10);
    wait_done(300);
    repeat (5) @(negedge clock);
    chk("t2_loads", loads, 12);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Auto-step, then halt requested during a step pulse.
    do_reset();
    run_en = 1'b1;
    send(4'hA, 1'b1, st);
    wait_done(100);
    n = 0;
    while (steps < 3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t3_steps", steps, 3);
    chk("t3_step_count", int'(step_count), 3);
    if (rise_cyc.size() >= 3) begin
      chk("t3_first_step_delay", rise_cyc[0] - done_cyc, 17);
      chk("t3_period_1", rise_cyc[1] - rise_cyc[0], 20);
      chk("t3_period_2", rise_cyc[2] - rise_cyc[1], 20);
    end
    wait_next(1'b0, 10);
    wait_next(1'b1, 40);
    bus.Compute_done = 1'b1;
    repeat (4) begin
      repeat (5) @(negedge clock);
      step_req = 1'b1;
      repeat (5) @(negedge clock);
      step_req = 1'b0;
    end
    chk("t5_halted", int'(halted), 1);
    chk("t5_steps", steps, 4);
    chk("t5_step_count", int'(step_count), 4);
    chk("t5_next_low", int'(bus.Next), 0);

    // Manual steps: second edge lands in STEP_HI and is held pending.
    bus.Compute_done = 1'b0;
    run_en = 1'b0;
    do_reset();
    send(4'h7, 1'b1, st);
    wait_done(100);
    step_req = 1'b1;
    @(negedge clock);
    step_req = 1'b0;
    wait_next(1'b1, 20);
    step_req = 1'b1;
    repeat (80) @(negedge clock);
    step_req = 1'b0;
    chk("t4_steps", steps, 2);
    chk("t4_step_count", int'(step_count), 2);
    chk("t4_halted", int'(halted), 0);

    // Asynchronous reset in the middle of a load pulse.
    do_reset();
    send(4'h6, 1'b1, st);
    wait_next(1'b1, 20);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_next", int'(bus.Next), 0);
    chk("mid_rst_done", int'(bus.Done), 0);
    chk("mid_rst_input_data", int'(bus.input_data), 0);
    chk("mid_rst_step_count", int'(step_count), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clock);
    @(negedge clock);
    Reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("post_rst_no_replay", loads, 0);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
